// File: rtl/acc_resp_buffer.sv
// acc_resp_buffer: in-order accelerator response FIFO with dispatch throttling (optional ACC_RESP_BUFFER_BYPASS_EN).
// Latency: 1 cycle response->writeback; 0 cycles when bypass is built in and the buffer is empty.
// Backpressure: resp_ready_o drops when full; req_allow_o drops once in-flight + buffered reaches Depth.
module acc_resp_buffer #(
    parameter int Depth        = 4,
    parameter int TransIdWidth = 3,
    parameter int Xlen         = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_fire_i,
    output logic                      req_allow_o,
    input  logic                      resp_valid_i,
    output logic                      resp_ready_o,
    input  logic [TransIdWidth-1:0]   resp_trans_id_i,
    input  logic [Xlen-1:0]           resp_result_i,
    input  logic                      resp_ex_valid_i,
    input  logic [Xlen-1:0]           resp_ex_cause_i,
    input  logic [Xlen-1:0]           resp_ex_tval_i,
    input  logic                      resp_fflags_valid_i,
    input  logic [4:0]                resp_fflags_i,
    output logic                      wb_valid_o,
    input  logic                      wb_ready_i,
    output logic [TransIdWidth-1:0]   wb_trans_id_o,
    output logic [Xlen-1:0]           wb_result_o,
    output logic                      wb_ex_valid_o,
    output logic [Xlen-1:0]           wb_ex_cause_o,
    output logic [Xlen-1:0]           wb_ex_tval_o,
    output logic                      wb_fflags_valid_o,
    output logic [4:0]                wb_fflags_o,
    output logic [$clog2(Depth):0]    outstanding_o,
    output logic                      spurious_o
);
    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [TransIdWidth-1:0] trans_id;
        logic [Xlen-1:0]         result;
        logic                    ex_valid;
        logic [Xlen-1:0]         ex_cause;
        logic [Xlen-1:0]         ex_tval;
        logic                    fflags_valid;
        logic [4:0]              fflags;
    } resp_t;

    resp_t          mem [Depth];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [CW-1:0]  awaiting;
    logic           spurious_q;

    logic [CW-1:0]  occ;
    logic [CW:0]    pending;
    logic           empty;
    logic           full;
    logic           resp_hs;
    logic           push;
    logic           pop;
    resp_t          in_ent;
    resp_t          head;
    resp_t          wb_ent;

    assign occ     = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pending = {1'b0, awaiting} + {1'b0, occ};

    assign req_allow_o   = (pending < (CW+1)'(Depth));
    assign outstanding_o = pending[CW-1:0];
    assign resp_ready_o  = !full;
    assign resp_hs       = resp_valid_i && resp_ready_o;
    assign spurious_o    = spurious_q;

    assign in_ent = '{trans_id:     resp_trans_id_i,
                      result:       resp_result_i,
                      ex_valid:     resp_ex_valid_i,
                      ex_cause:     resp_ex_cause_i,
                      ex_tval:      resp_ex_tval_i,
                      fflags_valid: resp_fflags_valid_i,
                      fflags:       resp_fflags_i};
    assign head   = mem[rd_ptr[AW-1:0]];
    assign pop    = wb_ready_i && !empty;

`ifdef ACC_RESP_BUFFER_BYPASS_EN
    logic bypass;
    // An empty buffer forwards the live response; it is only stored if writeback stalls.
    assign bypass     = empty && resp_valid_i;
    assign wb_valid_o = !empty || resp_valid_i;
    assign wb_ent     = bypass ? in_ent : head;
    assign push       = resp_hs && !(bypass && wb_ready_i);
`else
    assign wb_valid_o = !empty;
    assign wb_ent     = head;
    assign push       = resp_hs;
`endif

    assign wb_trans_id_o     = wb_ent.trans_id;
    assign wb_result_o       = wb_ent.result;
    assign wb_ex_valid_o     = wb_ent.ex_valid;
    assign wb_ex_cause_o     = wb_ent.ex_cause;
    assign wb_ex_tval_o      = wb_ent.ex_tval;
    assign wb_fflags_valid_o = wb_ent.fflags_valid;
    assign wb_fflags_o       = wb_ent.fflags;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            awaiting   <= '0;
            spurious_q <= 1'b0;
            for (int i = 0; i < Depth; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= in_ent;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            // A response with nothing awaited is kept but must not drive the counter below zero.
            awaiting   <= awaiting + CW'(req_fire_i) - CW'(resp_hs && (awaiting != '0));
            spurious_q <= resp_hs && (awaiting == '0);
        end
    end

    a_no_fire_when_throttled: assert property (@(posedge clk_i) disable iff (rst_i)
        req_fire_i |-> req_allow_o);

endmodule

// File: tb/tb_acc_resp_buffer.sv
// Bench for acc_resp_buffer: directed scenarios plus a writeback scoreboard fed by accepted responses.
module tb_acc_resp_buffer;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_fire_i = 1'b0;
    logic        req_allow_o;
    logic        resp_valid_i = 1'b0;
    logic        resp_ready_o;
    logic [2:0]  resp_trans_id_i = '0;
    logic [63:0] resp_result_i = '0;
    logic        resp_ex_valid_i = 1'b0;
    logic [63:0] resp_ex_cause_i = '0;
    logic [63:0] resp_ex_tval_i = '0;
    logic        resp_fflags_valid_i = 1'b0;
    logic [4:0]  resp_fflags_i = '0;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b0;
    logic [2:0]  wb_trans_id_o;
    logic [63:0] wb_result_o;
    logic        wb_ex_valid_o;
    logic [63:0] wb_ex_cause_o;
    logic [63:0] wb_ex_tval_o;
    logic        wb_fflags_valid_o;
    logic [4:0]  wb_fflags_o;
    logic [2:0]  outstanding_o;
    logic        spurious_o;

    typedef struct packed {
        logic [2:0]  trans_id;
        logic [63:0] result;
        logic        ex_valid;
        logic [63:0] ex_cause;
        logic [63:0] ex_tval;
        logic        fflags_valid;
        logic [4:0]  fflags;
    } ent_t;

    ent_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    acc_resp_buffer #(.Depth(4), .TransIdWidth(3), .Xlen(64)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_fire_i(req_fire_i), .req_allow_o(req_allow_o),
        .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o),
        .resp_trans_id_i(resp_trans_id_i), .resp_result_i(resp_result_i),
        .resp_ex_valid_i(resp_ex_valid_i), .resp_ex_cause_i(resp_ex_cause_i),
        .resp_ex_tval_i(resp_ex_tval_i), .resp_fflags_valid_i(resp_fflags_valid_i),
        .resp_fflags_i(resp_fflags_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_trans_id_o(wb_trans_id_o), .wb_result_o(wb_result_o),
        .wb_ex_valid_o(wb_ex_valid_o), .wb_ex_cause_o(wb_ex_cause_o),
        .wb_ex_tval_o(wb_ex_tval_o), .wb_fflags_valid_o(wb_fflags_valid_o),
        .wb_fflags_o(wb_fflags_o),
        .outstanding_o(outstanding_o), .spurious_o(spurious_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change just after posedge, so negedge sees exactly what the next edge will sample.
    always @(negedge clk_i) begin
        ent_t got;
        ent_t exp;
        if (rst_i) begin
            sb.delete();
        end else begin
            if (resp_valid_i && resp_ready_o)
                sb.push_back({resp_trans_id_i, resp_result_i, resp_ex_valid_i, resp_ex_cause_i,
                              resp_ex_tval_i, resp_fflags_valid_i, resp_fflags_i});
            if (wb_valid_o && wb_ready_i) begin
                got = {wb_trans_id_o, wb_result_o, wb_ex_valid_o, wb_ex_cause_o,
                       wb_ex_tval_o, wb_fflags_valid_o, wb_fflags_o};
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL wb_pop: popped id=%0d result=%h, required no entry", wb_trans_id_o, wb_result_o);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL wb_pop: got id=%0d res=%h ex=%0b fv=%0b ff=%h, required id=%0d res=%h ex=%0b fv=%0b ff=%h",
                                 got.trans_id, got.result, got.ex_valid, got.fflags_valid, got.fflags,
                                 exp.trans_id, exp.result, exp.ex_valid, exp.fflags_valid, exp.fflags);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_resp(input logic [2:0] id, input logic [63:0] res);
        resp_valid_i        = 1'b1;
        resp_trans_id_i     = id;
        resp_result_i       = res;
        resp_ex_valid_i     = 1'($urandom_range(0, 1));
        resp_ex_cause_i     = {$urandom, $urandom};
        resp_ex_tval_i      = {$urandom, $urandom};
        resp_fflags_valid_i = 1'($urandom_range(0, 1));
        resp_fflags_i       = 5'($urandom);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        chk("reset_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("reset_outstanding", 64'(outstanding_o), 64'd0);
        chk("reset_req_allow", 64'(req_allow_o), 64'd1);
        chk("reset_resp_ready", 64'(resp_ready_o), 64'd1);
        chk("reset_spurious", 64'(spurious_o), 64'd0);
        chk("reset_wb_result", wb_result_o, 64'd0);
        chk("reset_wb_trans_id", 64'(wb_trans_id_o), 64'd0);
    endtask

    task automatic test_round_trip();
        req_fire_i = 1'b1;
        tick();
        req_fire_i = 1'b0;
        chk("rt_outstanding_after_fire", 64'(outstanding_o), 64'd1);
        wb_ready_i = 1'b1;
        drive_resp(3'd5, 64'hDEAD_BEEF);
`ifdef ACC_RESP_BUFFER_BYPASS_EN
        chk("rt_bypass_same_cycle_valid", 64'(wb_valid_o), 64'd1);
        chk("rt_bypass_same_cycle_id", 64'(wb_trans_id_o), 64'd5);
        tick();
        resp_valid_i = 1'b0;
        #1;
        chk("rt_bypass_outstanding", 64'(outstanding_o), 64'd0);
`else
        chk("rt_no_same_cycle_valid", 64'(wb_valid_o), 64'd0);
        chk("rt_outstanding_resp_cycle", 64'(outstanding_o), 64'd1);
        tick();
        resp_valid_i = 1'b0;
        #1;
        chk("rt_wb_valid_next", 64'(wb_valid_o), 64'd1);
        chk("rt_wb_id", 64'(wb_trans_id_o), 64'd5);
        chk("rt_wb_result", wb_result_o, 64'hDEAD_BEEF);
        chk("rt_outstanding_buffered", 64'(outstanding_o), 64'd1);
        tick();
`endif
        chk("rt_wb_valid_done", 64'(wb_valid_o), 64'd0);
        chk("rt_outstanding_done", 64'(outstanding_o), 64'd0);
        wb_ready_i = 1'b0;
    endtask

    task automatic test_throttle();
        for (int i = 0; i < 4; i++) begin
            chk("thr_allow_before_fire", 64'(req_allow_o), 64'd1);
            req_fire_i = 1'b1;
            tick();
        end
        req_fire_i = 1'b0;
        chk("thr_allow_after_4", 64'(req_allow_o), 64'd0);
        chk("thr_outstanding_4", 64'(outstanding_o), 64'd4);
        for (int i = 0; i < 4; i++) begin
            drive_resp(3'(i), 64'(32'hA000 + i));
            tick();
        end
        resp_valid_i = 1'b0;
        #1;
        chk("thr_full_resp_ready", 64'(resp_ready_o), 64'd0);
        chk("thr_full_outstanding", 64'(outstanding_o), 64'd4);
        chk("thr_full_spurious", 64'(spurious_o), 64'd0);
        // A response offered while full must be refused even though a pop happens the same cycle.
        drive_resp(3'd7, 64'h7777);
        wb_ready_i = 1'b1;
        tick();
        resp_valid_i = 1'b0;
        wb_ready_i   = 1'b0;
        #1;
        chk("thr_pop_allow", 64'(req_allow_o), 64'd1);
        chk("thr_pop_outstanding", 64'(outstanding_o), 64'd3);
        chk("thr_pop_resp_ready", 64'(resp_ready_o), 64'd1);
        chk("thr_refused_no_spurious", 64'(spurious_o), 64'd0);
        wb_ready_i = 1'b1;
        tick();
        tick();
        tick();
        wb_ready_i = 1'b0;
        chk("thr_drained_valid", 64'(wb_valid_o), 64'd0);
        chk("thr_drained_outstanding", 64'(outstanding_o), 64'd0);
    endtask

    task automatic test_order_stall();
        logic [63:0] res1;
        req_fire_i = 1'b1;
        tick();
        tick();
        tick();
        req_fire_i = 1'b0;
        res1 = {$urandom, $urandom};
        drive_resp(3'd1, res1);
        tick();
        drive_resp(3'd2, {$urandom, $urandom});
        tick();
        drive_resp(3'd3, {$urandom, $urandom});
        tick();
        resp_valid_i = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(wb_valid_o), 64'd1);
            chk("stall_id", 64'(wb_trans_id_o), 64'd1);
            chk("stall_result", wb_result_o, res1);
            tick();
        end
        wb_ready_i = 1'b1;
        #1;
        chk("order_id1", 64'(wb_trans_id_o), 64'd1);
        tick();
        chk("order_id2", 64'(wb_trans_id_o), 64'd2);
        chk("order_valid2", 64'(wb_valid_o), 64'd1);
        tick();
        chk("order_id3", 64'(wb_trans_id_o), 64'd3);
        chk("order_valid3", 64'(wb_valid_o), 64'd1);
        tick();
        chk("order_empty", 64'(wb_valid_o), 64'd0);
        wb_ready_i = 1'b0;
    endtask

    task automatic test_simultaneous();
        req_fire_i = 1'b1;
        tick();
        tick();
        req_fire_i = 1'b0;
        drive_resp(3'd4, 64'h4444);
        tick();
        resp_valid_i = 1'b0;
        #1;
        chk("sim_setup_outstanding", 64'(outstanding_o), 64'd2);
        req_fire_i = 1'b1;
        wb_ready_i = 1'b1;
        drive_resp(3'd5, 64'h5555);
        tick();
        req_fire_i   = 1'b0;
        resp_valid_i = 1'b0;
        wb_ready_i   = 1'b0;
        #1;
        chk("sim_outstanding", 64'(outstanding_o), 64'd2);
        chk("sim_wb_valid", 64'(wb_valid_o), 64'd1);
        chk("sim_head_id", 64'(wb_trans_id_o), 64'd5);
        wb_ready_i = 1'b1;
        drive_resp(3'd6, 64'h6666);
        tick();
        resp_valid_i = 1'b0;
        #1;
        chk("sim_pushpop_outstanding", 64'(outstanding_o), 64'd1);
        chk("sim_pushpop_spurious", 64'(spurious_o), 64'd0);
        tick();
        wb_ready_i = 1'b0;
        chk("sim_drained", 64'(outstanding_o), 64'd0);
    endtask

    task automatic test_spurious();
        drive_resp(3'd6, 64'hCAFE);
        tick();
        resp_valid_i = 1'b0;
        #1;
        chk("spur_pulse", 64'(spurious_o), 64'd1);
        chk("spur_stored_valid", 64'(wb_valid_o), 64'd1);
        chk("spur_stored_id", 64'(wb_trans_id_o), 64'd6);
        chk("spur_outstanding", 64'(outstanding_o), 64'd1);
        tick();
        chk("spur_pulse_end", 64'(spurious_o), 64'd0);
        chk("spur_still_valid", 64'(wb_valid_o), 64'd1);
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;
        chk("spur_drained", 64'(outstanding_o), 64'd0);
    endtask

    task automatic test_bypass();
        wb_ready_i = 1'b1;
        drive_resp(3'd2, 64'hB0B0);
`ifdef ACC_RESP_BUFFER_BYPASS_EN
        chk("byp_same_cycle_valid", 64'(wb_valid_o), 64'd1);
        chk("byp_same_cycle_result", wb_result_o, 64'hB0B0);
`else
        chk("byp_none_same_cycle", 64'(wb_valid_o), 64'd0);
`endif
        tick();
        resp_valid_i = 1'b0;
        #1;
        chk("byp_spurious", 64'(spurious_o), 64'd1);
`ifdef ACC_RESP_BUFFER_BYPASS_EN
        chk("byp_outstanding", 64'(outstanding_o), 64'd0);
`else
        chk("byp_outstanding", 64'(outstanding_o), 64'd1);
`endif
        tick();
        wb_ready_i = 1'b0;
        chk("byp_final_valid", 64'(wb_valid_o), 64'd0);
        chk("byp_final_outstanding", 64'(outstanding_o), 64'd0);
    endtask

    task automatic test_reset_mid();
        req_fire_i = 1'b1;
        tick();
        tick();
        req_fire_i = 1'b0;
        drive_resp(3'd3, 64'h3333);
        tick();
        rst_i      = 1'b1;
        req_fire_i = 1'b1;
        drive_resp(3'd4, 64'h4444);
        tick();
        rst_i        = 1'b0;
        req_fire_i   = 1'b0;
        resp_valid_i = 1'b0;
        #1;
        chk("mid_rst_outstanding", 64'(outstanding_o), 64'd0);
        chk("mid_rst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("mid_rst_spurious", 64'(spurious_o), 64'd0);
        chk("mid_rst_allow", 64'(req_allow_o), 64'd1);
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_throttle();
        test_order_stall();
        test_simultaneous();
        test_spurious();
        test_bypass();
        test_reset_mid();
        tick();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
